ram_2p_clr: RTL

//   Parametrised simple-dual-port RAM for the minicpu data path: one write port and one read port

---
 rtl/ram_2p_clr.sv | 91 +++++++++
 1 files changed

// File: rtl/ram_2p_clr.sv
// Simple-dual-port RAM with registered, write-first reads and a post-reset clear sequencer.
// One write port and one read port per cycle; both ports are ignored while busy.
module ram_2p_clr #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADR_W     = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              we,
    input  logic [ADR_W-1:0]  wadr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADR_W-1:0]  radr,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid
);

    localparam int unsigned DEPTH = 2 ** ADR_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t             state;
    logic [ADR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               mem_we;
    logic [ADR_W-1:0]   mem_wadr;
    logic [DATA_W-1:0]  mem_wdat;

    // The clear sequencer owns the write port until it finishes; user writes are dropped.
    always_comb begin
        mem_we   = 1'b0;
        mem_wadr = '0;
        mem_wdat = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we   = 1'b1;
                mem_wadr = clr_cnt;
                mem_wdat = CLEAR_VAL;
            end else if (we) begin
                mem_we   = 1'b1;
                mem_wadr = wadr;
                mem_wdat = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wadr] <= mem_wdat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
            dout    <= '0;
            dvalid  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    dvalid  <= 1'b0;
                    clr_cnt <= clr_cnt + ADR_W'(1);
                    if (clr_cnt == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    dvalid <= re;
                    if (re) begin
                        // Write-first: a same-address write this cycle is forwarded to the read.
                        dout <= (we && (wadr == radr)) ? din : mem[radr];
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
